// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: widths, FSM states and
// the error-cause codes used when classifying an access.
package dm_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } dmState_e;

  // Error causes; an access errs when any cause bit is set.
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;

endpackage

// File: rtl/dm_array.sv
// Word-organised storage: asynchronous clear, registered byte-enabled write,
// combinational read.
module dm_array
  import dm_pkg::*;
#(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [AW-1:0]     wAddr,
  input  logic [WORD_W-1:0] wData,
  input  logic [BE_W-1:0]   wBe,
  input  logic [AW-1:0]     rAddr,
  output logic [WORD_W-1:0] rData
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wBe[b]) mem[wAddr][8*b +: 8] <= wData[8*b +: 8];
      end
    end
  end

  assign rData = mem[rAddr];

endmodule

// File: rtl/dm_resp.sv
// Data-memory responder: accepts one request, waits WAIT_CYCLES, performs the
// array access, then holds the response until the initiator takes it.
module dm_resp
  import dm_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall,
  output logic [1:0]  dbgState
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready does not depend on valid, and valid/data hold until taken.
  dmState_e state, nextState;

  logic [3:0]  cnt;
  logic        bufWe;
  logic [31:0] bufAddr;
  logic [31:0] bufWdata;
  logic [3:0]  bufBe;
  logic [31:0] rdataQ;
  logic        errQ;

  logic [31:0] off;
  logic [31:0] wordOff;
  logic        accErr;
  logic        arrWe;
  logic [31:0] arrRdata;

  // Modulo-2^32 offset: addresses below the base wrap high and fail the range test.
  assign off     = bufAddr - BASE_ADDR;
  assign wordOff = off >> 2;
  assign accErr  = (bufAddr[1:0] != 2'b00) || (wordOff >= 32'(DEPTH_WORDS));
  assign arrWe   = (state == S_ACCESS) && !accErr && bufWe;

  dm_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .clr   (clr),
    .we    (arrWe),
    .wAddr (wordOff[AW-1:0]),
    .wData (bufWdata),
    .wBe   (bufBe),
    .rAddr (wordOff[AW-1:0]),
    .rData (arrRdata)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE:   if (req_valid) nextState = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (cnt == 4'd0) nextState = S_ACCESS;
      S_ACCESS: nextState = S_RESP;
      S_RESP:   if (rsp_ready) nextState = S_IDLE;
      default:  nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt      <= '0;
      bufWe    <= 1'b0;
      bufAddr  <= '0;
      bufWdata <= '0;
      bufBe    <= '0;
      rdataQ   <= '0;
      errQ     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            bufWe    <= req_we;
            bufAddr  <= req_addr;
            bufWdata <= req_wdata;
            bufBe    <= req_be;
            cnt      <= CNT_INIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        S_ACCESS: begin
          rdataQ <= (!accErr && !bufWe) ? arrRdata : '0;
          errQ   <= accErr;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rdataQ <= '0;
            errQ   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign stall     = (state != S_IDLE);
  assign rsp_rdata = rdataQ;
  assign rsp_err   = errQ;
  assign dbgState  = state;

endmodule

// File: tb/tb_dm_resp.sv
// Bench for dm_resp: directed cases with literal expectations, then random
// traffic checked every cycle against a transaction-level memory model.
module tb_dm_resp;
  import dm_pkg::*;

  localparam int          DEPTH = 1024;
  localparam int          W     = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk;
  logic        clr;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;
  logic [1:0]  dbgState;

  dm_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .stall     (stall),
    .dbgState  (dbgState)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one transaction in flight, identified only by its age in cycles.
  bit          busy = 1'b0;
  int          age  = 0;
  logic        mWe;
  logic [31:0] mAddr;
  logic [31:0] mWdata;
  logic [3:0]  mBe;
  logic [31:0] mem_m [DEPTH];
  logic [32:0] exp_q [$];

  function automatic logic [32:0] modelResult();
    logic [31:0] moff;
    logic [31:0] idx;
    logic [1:0]  cause;
    moff  = mAddr - BASE;
    idx   = moff >> 2;
    cause = ERR_NONE;
    if (mAddr[1:0] != 2'b00) cause |= ERR_MISALIGN;
    if (idx >= DEPTH)        cause |= ERR_RANGE;
    if (cause != ERR_NONE) return {1'b1, 32'h0};
    if (mWe) begin
      for (int b = 0; b < 4; b++)
        if (mBe[b]) mem_m[idx][8*b +: 8] = mWdata[8*b +: 8];
      return {1'b0, 32'h0};
    end
    return {1'b0, mem_m[idx]};
  endfunction

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      busy = 1'b0;
      age  = 0;
      exp_q.delete();
      foreach (mem_m[i]) mem_m[i] = '0;
    end else if (!busy) begin
      if (req_valid) begin
        busy   = 1'b1;
        age    = 0;
        mWe    = req_we;
        mAddr  = req_addr;
        mWdata = req_wdata;
        mBe    = req_be;
      end
    end else if (age < W + 1) begin
      age++;
      if (age == W + 1) exp_q.push_back(modelResult());
    end else if (rsp_ready) begin
      busy = 1'b0;
      void'(exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    logic expValid;
    expValid = busy && (age >= W + 1);
    check("req_ready", req_ready, !busy);
    check("stall", stall, busy);
    check("rsp_valid", rsp_valid, expValid);
    if (expValid) begin
      if (exp_q.size() != 1) check("exp_q_size", exp_q.size(), 1);
      else begin
        check("rsp_rdata", rsp_rdata, exp_q[0][31:0]);
        check("rsp_err", rsp_err, exp_q[0][32]);
      end
    end else begin
      check("idle_rdata", rsp_rdata, 32'h0);
      check("idle_err", rsp_err, 1'b0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sendReq(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    for (int i = 0; i < 40; i++) begin
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Scramble the request lines after acceptance; the DUT must ignore them.
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
  endtask

  task automatic getRsp(input int hold, input bit poke, output logic [31:0] rd,
                        output logic err, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = -1;
    rd   = '0;
    err  = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
    end
    if (!seen) begin
      check("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    rd  = rsp_rdata;
    err = rsp_err;
    if (poke) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h0000_0040;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_rdata", rsp_rdata, rd);
      check("hold_err", rsp_err, err);
      check("hold_req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    if (poke) begin
      @(negedge clk);
      check("poke_ready_after", req_ready, 1'b1);
      req_valid = 1'b0;
    end
  endtask

  task automatic doTxn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold, input bit poke,
                       output logic [31:0] rd, output logic err, output int lat);
    bit ok;
    rd  = '0;
    err = 1'b0;
    lat = -1;
    sendReq(we, addr, wdata, be, ok);
    if (ok) getRsp(hold, poke, rd, err, lat);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  logic        err;
  int          lat;
  bit          ok;

  initial begin
    clr       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_stall", stall, 1'b0);
    clr = 1'b1;

    doTxn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 1'b0, rd, err, lat);
    check("first_load_rdata", rd, 32'h0);
    check("first_load_err", err, 1'b0);

    doTxn(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, rd, err, lat);
    check("store40_err", err, 1'b0);
    check("store40_lat", lat, 32'd3);
    doTxn(1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 1'b0, rd, err, lat);
    check("load40_rdata", rd, 32'hDEAD_BEEF);
    check("load40_lat", lat, 32'd3);

    doTxn(1'b1, 32'h0000_0080, 32'h1122_3344, 4'hF, 0, 1'b0, rd, err, lat);
    doTxn(1'b1, 32'h0000_0080, 32'hAABB_CCDD, 4'b0101, 1, 1'b0, rd, err, lat);
    doTxn(1'b0, 32'h0000_0080, 32'h0, 4'h0, 0, 1'b0, rd, err, lat);
    check("partial_rdata", rd, 32'h11BB_33DD);

    doTxn(1'b0, 32'h0000_0042, 32'h0, 4'h0, 0, 1'b0, rd, err, lat);
    check("misalign_err", err, 1'b1);
    check("misalign_rdata", rd, 32'h0);

    doTxn(1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, 0, 1'b0, rd, err, lat);
    doTxn(1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, rd, err, lat);
    check("range_err", err, 1'b1);
    doTxn(1'b0, 32'h0000_0000, 32'h0, 4'h0, 0, 1'b0, rd, err, lat);
    check("word0_unchanged", rd, 32'h1234_5678);

    doTxn(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 0, 1'b0, rd, err, lat);
    check("wrap_err", err, 1'b1);

    doTxn(1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4'h0, 0, 1'b0, rd, err, lat);
    check("be0_err", err, 1'b0);
    doTxn(1'b0, 32'h0000_0040, 32'h0, 4'h0, 5, 1'b1, rd, err, lat);
    check("backpressure_rdata", rd, 32'hDEAD_BEEF);

    // Reset while a store sits in WAIT.
    sendReq(1'b1, 32'h0000_0020, 32'h5A5A_5A5A, 4'hF, ok);
    @(negedge clk);
    #2;
    clr = 1'b0;
    #1;
    check("midreset_state", dbgState, S_IDLE);
    check("midreset_req_ready", req_ready, 1'b1);
    check("midreset_stall", stall, 1'b0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    doTxn(1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, 1'b0, rd, err, lat);
    check("midreset_load20", rd, 32'h0);
    check("midreset_err", err, 1'b0);

    // Random traffic over a small window plus error addresses.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      int          sel;
      sel = $urandom_range(0, 9);
      if (sel <= 6)      a = 32'($urandom_range(0, 15)) << 2;
      else if (sel == 7) a = (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(1, 3));
      else if (sel == 8) a = 32'h0000_1000 + (32'($urandom_range(0, 15)) << 2);
      else               a = $urandom;
      doTxn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), rd, err, lat);
      check("rand_lat", lat, W + 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
